// File: rtl/step_scheduler.sv
// Step scheduler: IDLE/RUN/PAUSED timer that issues step_req/step_ack handshakes.
// Optional accepted-step counter enabled by defining STEP_SCHEDULER_COUNT_EN.
module step_scheduler #(
  parameter int PERIOD = 25000000,
  parameter int CW     = 26
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        single,
  input  logic [1:0]  speed,
  output logic        step_req,
  input  logic        step_ack,
  output logic [1:0]  state,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_e;

  localparam logic [CW-1:0] PERIOD_W = CW'(PERIOD);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit;
  logic          tick_q, tick_d;
  logic          req_q, req_d;
  logic          ovr_q, ovr_d;
  logic          run_stay;
  logic          at_limit;

  // Speed is applied combinationally so a mid-period change takes effect at once.
  assign limit    = (PERIOD_W >> speed) - CW'(1);
  assign at_limit = (cnt_q >= limit);

  always_comb begin
    run_stay = (state_q == S_RUN) && !stop && !pause;

    state_d = state_q;
    if (stop)
      state_d = S_IDLE;
    else if (pause) begin
      if (state_q == S_RUN)
        state_d = S_PAUSED;
    end else if (start && (state_q != S_RUN))
      state_d = S_RUN;

    tick_d = (run_stay && at_limit) ||
             ((state_q == S_PAUSED) && single && !stop);

    // Cleared on IDLE entry and on IDLE->RUN; held while paused.
    if ((state_d == S_IDLE) || (state_q == S_IDLE))
      cnt_d = '0;
    else if (run_stay)
      cnt_d = at_limit ? '0 : cnt_q + CW'(1);
    else
      cnt_d = cnt_q;

    // A tick arriving while a request is outstanding (ack cycle included) is dropped.
    req_d = req_q;
    if (state_d == S_IDLE)
      req_d = 1'b0;
    else if (req_q)
      req_d = !step_ack;
    else if (tick_q)
      req_d = 1'b1;

    if (tick_q && req_q)
      ovr_d = 1'b1;
    else if (overrun_clr)
      ovr_d = 1'b0;
    else
      ovr_d = ovr_q;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      req_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      req_q   <= req_d;
      ovr_q   <= ovr_d;
    end
  end

  assign state    = state_q;
  assign step_req = req_q;
  assign overrun  = ovr_q;

`ifdef STEP_SCHEDULER_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_d == S_IDLE)
      count_d = '0;
    else if (req_q && step_ack)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign step_count = count_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler at PERIOD=8: table-driven cycle vectors plus a
// scoreboard of expected step_req rising-edge cycles.
module tb_step_scheduler;

  logic        clk_in;
  logic        reset_n;
  logic        start, stop, pause, single;
  logic [1:0]  speed;
  logic        step_req;
  logic        step_ack;
  logic [1:0]  state;
  logic        overrun;
  logic        overrun_clr;
  logic [15:0] step_count;

  logic ack_auto, ack_follow, ack_man;
  assign step_ack = ack_auto ? ack_follow : ack_man;

  step_scheduler #(.PERIOD(8), .CW(26)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .single      (single),
    .speed       (speed),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .state       (state),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .step_count  (step_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       start, stop, pause, ack, clr;
    logic [1:0] speed;
    logic [1:0] st;
    logic       req, ov;
  } vec_t;

  int   n_vec = 0;
  int   errs  = 0;
  int   cyc   = 0;
  int   sb_q[$];
  logic sb_on   = 1'b0;
  logic req_prev = 1'b0;

`ifdef STEP_SCHEDULER_COUNT_EN
  localparam int EXP_CNT3 = 3;
`else
  localparam int EXP_CNT3 = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock; also runs the ack responder and the step_req scoreboard monitor.
  task automatic cyc1();
    @(posedge clk_in);
    #1;
    cyc++;
    ack_follow = step_req;
    if (sb_on && step_req && !req_prev) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        errs++;
        $display("FAIL req_rise: unexpected rise at cycle %0d, expected none", cyc);
      end else
        chk("req_rise_cycle", cyc, sb_q.pop_front());
    end
    req_prev = step_req;
  endtask

  task automatic wait_q_empty(input string nm, input int max);
    for (int i = 0; i < max && sb_q.size() != 0; i++) cyc1();
    if (sb_q.size() != 0) begin
      n_vec++;
      errs++;
      $display("FAIL %s: %0d expected req rises still pending, required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic vec_t mk(input int a_start, a_stop, a_pause, a_ack, a_clr,
                              a_speed, e_st, e_req, e_ov);
    vec_t v;
    v.start = 1'(a_start); v.stop = 1'(a_stop); v.pause = 1'(a_pause);
    v.ack   = 1'(a_ack);   v.clr  = 1'(a_clr);  v.speed = 2'(a_speed);
    v.st    = 2'(e_st);    v.req  = 1'(e_req);  v.ov    = 1'(e_ov);
    return v;
  endfunction

  initial begin
    vec_t tbl [18];
    int   k0, ks, rises;
    logic prev;

    // Rows are one clock each, starting from IDLE with the counter at 0.
    //            st sp pa ak cl spd | state req ov
    tbl[0]  = mk(1, 0, 0, 0, 0, 2,   1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 2,   1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 2,   1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 2,   1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 2,   1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 2,   1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 2,   1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0,   1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 3,   1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 3,   1, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 3,   1, 1, 1);
    tbl[15] = mk(0, 0, 0, 1, 1, 3,   1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 1, 0,   1, 1, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 0,   1, 0, 0);

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; single = 1'b0;
    speed = 2'd0; overrun_clr = 1'b0;
    ack_auto = 1'b0; ack_follow = 1'b0; ack_man = 1'b0;

    repeat (2) cyc1();
    chk("rst_state", state, 0);
    chk("rst_req", step_req, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_count", step_count, 0);
    reset_n = 1'b1;
    repeat (3) cyc1();
    chk("idle_after_rst", state, 0);

    // Free run at full period with immediate acks.
    start = 1'b1; ack_auto = 1'b1;
    cyc1();
    k0 = cyc;
    for (int i = 0; i < 4; i++) sb_q.push_back(k0 + 9 + 8 * i);
    sb_on = 1'b1;
    wait_q_empty("run_period", 60);
    sb_on = 1'b0; ack_auto = 1'b0;
    chk("run_ovr", overrun, 0);
    chk("run_state", state, 1);
    start = 1'b0; stop = 1'b1;
    cyc1();
    stop = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_req", step_req, 0);

    // Speed-change table.
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; pause = tbl[i].pause;
      ack_man = tbl[i].ack; overrun_clr = tbl[i].clr; speed = tbl[i].speed;
      cyc1();
      chk($sformatf("tbl%0d_state", i), state, 32'(tbl[i].st));
      chk($sformatf("tbl%0d_req", i), step_req, 32'(tbl[i].req));
      chk($sformatf("tbl%0d_ovr", i), overrun, 32'(tbl[i].ov));
    end
    ack_man = 1'b0; overrun_clr = 1'b0; speed = 2'd0;

    // Consumer stalls: one request held, second tick flags overrun.
    rises = 0; prev = step_req;
    for (int e = 1; e <= 20; e++) begin
      cyc1();
      if (step_req && !prev) rises++;
      prev = step_req;
      if (e == 14) chk("stall_ovr_pre", overrun, 0);
      if (e == 15) chk("stall_ovr_set", overrun, 1);
    end
    chk("stall_rises", rises, 1);
    chk("stall_req_held", step_req, 1);

    // Stop mid-handshake drops the request but keeps overrun.
    stop = 1'b1;
    cyc1();
    stop = 1'b0;
    chk("stop_hs_state", state, 0);
    chk("stop_hs_req", step_req, 0);
    chk("stop_hs_ovr", overrun, 1);
    chk("stop_hs_count", step_count, 0);
    overrun_clr = 1'b1;
    cyc1();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Pause at cnt=3, single step, then resume.
    ack_auto = 1'b1; sb_on = 1'b1;
    start = 1'b1;
    cyc1();
    start = 1'b0;
    repeat (3) cyc1();
    pause = 1'b1;
    cyc1();
    chk("paused_state", state, 2);
    repeat (9) cyc1();
    single = 1'b1;
    cyc1();
    single = 1'b0;
    sb_q.push_back(cyc + 1);
    repeat (4) cyc1();
    chk("single_once", sb_q.size(), 0);
    chk("still_paused", state, 2);
    pause = 1'b0; start = 1'b1;
    cyc1();
    ks = cyc;
    start = 1'b0;
    chk("resume_state", state, 1);
    sb_q.push_back(ks + 6);
    wait_q_empty("resume_tick", 20);
    sb_on = 1'b0;

    // Three acked steps, then async reset mid-handshake.
    stop = 1'b1;
    cyc1();
    stop = 1'b0; start = 1'b1;
    cyc1();
    start = 1'b0;
    repeat (27) cyc1();
    chk("count3", step_count, EXP_CNT3);
    ack_auto = 1'b0;
    for (int i = 0; i < 30 && !overrun; i++) cyc1();
    chk("pre_rst_ovr", overrun, 1);
    chk("pre_rst_req", step_req, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_req", step_req, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_count", step_count, 0);
    repeat (2) cyc1();
    reset_n = 1'b1;
    repeat (4) cyc1();
    chk("post_rst_state", state, 0);
    chk("post_rst_req", step_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter PERIOD, default 25000000, base step period in clk_in cycles (0.25 s at 100 MHz); legal range 8..2^26-1.
REQ-002 SHALL have parameter CW, default 26, period counter width; PERIOD < 2^CW.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports start / stop / pause  input  1 each  level-sampled run controls.
REQ-006 SHALL have port single  input  1  one-cycle pulse: request one step while PAUSED.
REQ-007 SHALL have port speed  input  2  rate select; effective period = PERIOD >> speed.
REQ-008 SHALL have ports step_req  output  1 and step_ack  input  1  step handshake to the consumer datapath.
REQ-009 SHALL have port state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSED.
REQ-010 SHALL have ports overrun  output  1 (sticky) and overrun_clr  input  1.
REQ-011 SHALL have port step_count  output  16  accepted-step counter (see Configuration).

Function
REQ-012 SHALL implement FSM IDLE/RUN/PAUSED; input priority each cycle: stop > pause > start.
REQ-013 SHALL go IDLE->RUN on start; RUN->PAUSED on pause; PAUSED->RUN on start with pause low; any state->IDLE on stop.
REQ-014 SHALL clear the period counter to 0 on every entry to IDLE and on the IDLE->RUN transition.
REQ-015 SHALL increment the counter in RUN only; SHALL hold it in PAUSED.
REQ-016 SHALL raise an internal tick when, in RUN, cnt >= (PERIOD>>speed)-1; same cycle cnt returns to 0.
REQ-017 A speed change mid-period SHALL take effect immediately; if cnt already >= new limit-1, tick on the next RUN cycle.
REQ-018 A single pulse in PAUSED SHALL produce one tick; single ignored in IDLE and RUN.
REQ-019 SHALL assert step_req in the cycle after a tick when step_req is low; step_req SHALL hold high until step_ack sampled high.
REQ-020 step_req SHALL deassert in the cycle after the cycle where step_req and step_ack are both high; step_ack while step_req low ignored.
REQ-021 A tick while step_req high (including the ack cycle) SHALL NOT create a new request and SHALL set overrun.
REQ-022 overrun SHALL clear on overrun_clr; if set and clear coincide, set wins.
REQ-023 Entry to IDLE via stop SHALL drop step_req the next cycle regardless of step_ack; overrun retained.
REQ-024 Tick-to-step_req latency SHALL be exactly 1 cycle; start-to-first-tick SHALL be (PERIOD>>speed) cycles after entering RUN.

Reset
REQ-025 On reset_n low, asynchronously: state=IDLE, counter=0, step_req=0, overrun=0, step_count=0.
REQ-026 Reset mid-handshake SHALL abandon the pending step; no step counted.
REQ-027 Deassertion of reset_n SHALL leave the block in IDLE until start.

Configuration
REQ-028 Macro STEP_SCHEDULER_COUNT_EN SHALL gate the step counter.
REQ-029 With STEP_SCHEDULER_COUNT_EN defined: step_count SHALL increment by 1 per completed handshake (REQ-020), wrap 0xFFFF->0x0000, clear on IDLE entry.
REQ-030 Without it: step_count SHALL be tied to 0 and no counter register instantiated; all other behaviour unchanged.

Verification (PERIOD=8)
REQ-031 Reset, start high, speed=0, ack 1 cycle after each req -> first step_req 9 cycles after start sample, then every 8 cycles; overrun stays 0.
REQ-032 RUN, speed=2 -> step_req every 2 cycles; switch speed 0->3 with cnt=5 -> tick next cycle, then every 1 cycle.
REQ-033 RUN, step_ack held low for 20 cycles -> single step_req held high, overrun=1 after second tick; overrun_clr -> 0.
REQ-034 pause at cnt=3, hold 10 cycles, single pulse -> exactly one step_req, cnt stays 3; start -> tick 5 cycles later.
REQ-035 stop with step_req high and ack low -> state=0 and step_req=0 next cycle; with COUNT_EN step_count=0.
REQ-036 Assert reset_n low mid-period, asynchronously between edges -> all outputs 0 immediately; with COUNT_EN, 3 acked steps -> step_count=3.
